cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step controller deriving the 6502 clock, reset and cycle count
module cpu_run_ctrl #(
    parameter int unsigned DIV          = 6000000,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned RUN_CYCLES   = 0,
    parameter int unsigned DEBOUNCE     = 120000
) (
    input  logic        CLK,
    input  logic        R,
    input  logic        run,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [15:0] bp_addr,
    input  logic [15:0] addr_bus,
    output logic        cpu_clk,
    output logic        cpu_res,
    output logic [1:0]  state,
    output logic        bp_hit,
    output logic [31:0] cycle_count
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RESET_HOLD = 2'd0,
        S_RUN        = 2'd1,
        S_PAUSE      = 2'd2,
        S_DONE       = 2'd3
    } run_state_t;

    logic [TW-1:0] tick;
    logic          tick_hit;

    logic          sync1;
    logic          sync2;
    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic          step_pulse;

    run_state_t    st;
    logic          step_armed;
    logic [RW-1:0] rst_periods;

    logic [31:0]   next_count;
    logic          bp_match;
    logic          limit_hit;
    run_state_t    fall_state;

    assign tick_hit = (tick == TW'(DIV - 1));
    assign state    = st;

    // Free-running divider; the last count of each lap is the only edge cpu_clk may toggle on
    always_ff @(posedge CLK) begin
        if (R) begin
            tick <= '0;
        end else if (tick_hit) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // Synchronise the button, accept a new level after DEBOUNCE equal samples, pulse on 0->1
    always_ff @(posedge CLK) begin
        if (R) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db_level   <= 1'b0;
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync1      <= step_btn;
            sync2      <= sync1;
            step_pulse <= 1'b0;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
                db_level   <= sync2;
                db_cnt     <= '0;
                step_pulse <= sync2;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Outcome of a completed cycle: limit beats breakpoint beats a dropped run level
    always_comb begin
        next_count = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
        bp_match   = bp_en && (addr_bus == bp_addr);
        limit_hit  = (RUN_CYCLES != 0) && (next_count == 32'(RUN_CYCLES));
        fall_state = run ? S_RUN : S_PAUSE;
        if (bp_match) begin
            fall_state = S_PAUSE;
        end
        if (limit_hit) begin
            fall_state = S_DONE;
        end
    end

    // Run/step state machine; every decision is taken on a fall toggle so a started cycle always finishes
    always_ff @(posedge CLK) begin
        if (R) begin
            st          <= S_RESET_HOLD;
            cpu_clk     <= 1'b0;
            cpu_res     <= 1'b1;
            bp_hit      <= 1'b0;
            cycle_count <= '0;
            step_armed  <= 1'b0;
            rst_periods <= '0;
        end else begin
            case (st)
                S_RESET_HOLD: begin
                    if (tick_hit) begin
                        cpu_clk <= ~cpu_clk;
                        if (cpu_clk) begin
                            if (rst_periods == RW'(RESET_CYCLES - 1)) begin
                                cpu_res <= 1'b0;
                                st      <= S_RUN;
                            end else begin
                                rst_periods <= rst_periods + RW'(1);
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (tick_hit) begin
                        cpu_clk <= ~cpu_clk;
                        if (cpu_clk) begin
                            cycle_count <= next_count;
                            st          <= fall_state;
                            if (bp_match) begin
                                bp_hit <= 1'b1;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (step_armed || cpu_clk) begin
                        // A stepped cycle is in flight; further step pulses are dropped
                        if (tick_hit) begin
                            cpu_clk    <= ~cpu_clk;
                            step_armed <= 1'b0;
                            if (cpu_clk) begin
                                cycle_count <= next_count;
                                st          <= fall_state;
                                if (bp_match) begin
                                    bp_hit <= 1'b1;
                                end
                            end
                        end
                    end else if (step_pulse) begin
                        step_armed <= 1'b1;
                        bp_hit     <= 1'b0;
                    end else if (run && !bp_hit) begin
                        st <= S_RUN;
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - randomized scoreboard bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

    localparam int DIV          = 2;
    localparam int RESET_CYCLES = 2;
    localparam int RUN_CYCLES   = 30;
    localparam int DEBOUNCE     = 4;

    logic        CLK      = 1'b0;
    logic        R        = 1'b1;
    logic        run      = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en    = 1'b0;
    logic [15:0] bp_addr  = 16'h0000;
    logic [15:0] addr_bus = 16'h0000;
    logic        cpu_clk;
    logic        cpu_res;
    logic [1:0]  state;
    logic        bp_hit;
    logic [31:0] cycle_count;

    int passed = 0;
    int total  = 0;

    // Expected result of one completed CPU cycle
    typedef struct {
        longint count;
        int     st;
        int     hit;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    longint m_count = 0;
    int     m_state = 0;
    int     m_hit   = 0;

    int   rel_edge   = 0;
    int   rise_cnt   = 0;
    int   fall_cnt   = 0;
    int   rise_edge  = 0;
    int   first_rise = -1;
    int   res_fall   = -1;
    logic prev_clk   = 1'b0;
    logic prev_res   = 1'b1;

    cpu_run_ctrl #(
        .DIV          (DIV),
        .RESET_CYCLES (RESET_CYCLES),
        .RUN_CYCLES   (RUN_CYCLES),
        .DEBOUNCE     (DEBOUNCE)
    ) dut (
        .CLK         (CLK),
        .R           (R),
        .run         (run),
        .step_btn    (step_btn),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .addr_bus    (addr_bus),
        .cpu_clk     (cpu_clk),
        .cpu_res     (cpu_res),
        .state       (state),
        .bp_hit      (bp_hit),
        .cycle_count (cycle_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one completed cycle, decided from the inputs presented for it
    task automatic model_cycle();
        exp_t e;
        logic bpm;
        bpm = bp_en && (addr_bus == bp_addr);
        if (m_count < 64'h0000_0000_FFFF_FFFF) m_count++;
        if (RUN_CYCLES != 0 && m_count == RUN_CYCLES) m_state = 3;
        else if (bpm)                                 m_state = 2;
        else if (!run)                                m_state = 2;
        else                                          m_state = 1;
        if (bpm) m_hit = 1;
        e.count = m_count;
        e.st    = m_state;
        e.hit   = m_hit;
        sb.push_back(e);
    endtask

    // Monitor: tracks cpu_clk edges, checks half-period, pops the scoreboard on every counted fall
    always @(posedge CLK) begin
        #1;
        if (R) begin
            rel_edge   = 0;
            first_rise = -1;
            res_fall   = -1;
        end else begin
            rel_edge++;
            if (!prev_clk && cpu_clk) begin
                rise_cnt++;
                rise_edge = rel_edge;
                if (first_rise < 0) first_rise = rel_edge;
            end
            if (prev_res && !cpu_res) res_fall = rel_edge;
            if (prev_clk && !cpu_clk) begin
                check("half_period", rel_edge - rise_edge, DIV);
                if (!prev_res) begin
                    fall_cnt++;
                    check("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("cycle_count", cycle_count, mon_e.count);
                        check("state", state, mon_e.st);
                        check("bp_hit", bp_hit, mon_e.hit);
                        check("cpu_res", cpu_res, 0);
                    end
                end
            end
        end
        prev_clk = cpu_clk;
        prev_res = cpu_res;
    end

    task automatic wait_rise();
        int r0 = rise_cnt;
        int n  = 0;
        while (rise_cnt == r0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("rise_seen", rise_cnt != r0, 1);
    endtask

    task automatic wait_fall();
        int f0 = fall_cnt;
        int n  = 0;
        while (fall_cnt == f0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("fall_seen", fall_cnt != f0, 1);
    endtask

    task automatic start_run();
        int n = 0;
        @(negedge CLK);
        R        = 1'b1;
        run      = 1'b1;
        bp_en    = 1'b0;
        step_btn = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_cpu_clk", cpu_clk, 0);
        check("rst_cpu_res", cpu_res, 1);
        check("rst_state", state, 0);
        check("rst_count", cycle_count, 0);
        check("rst_bp_hit", bp_hit, 0);
        sb.delete();
        m_count = 0;
        m_state = 0;
        m_hit   = 0;
        for (int i = 0; i < 3; i++) model_cycle();
        R = 1'b0;
        while (rel_edge < 20 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("first_rise_edge", first_rise, DIV);
        check("res_release_edge", res_fall, 2 * DIV * RESET_CYCLES);
        check("count_at_edge20", cycle_count, 3);
        check("state_at_edge20", state, 1);
    endtask

    task automatic run_cycle();
        int p;
        wait_rise();
        p = $urandom_range(0, 9);
        if (p == 0) begin
            bp_en    = 1'b1;
            bp_addr  = 16'($urandom);
            addr_bus = bp_addr;
        end else begin
            if (p == 1) run = 1'b0;
            bp_en    = 1'($urandom_range(0, 1));
            bp_addr  = 16'($urandom);
            addr_bus = 16'($urandom);
        end
        model_cycle();
        wait_fall();
    endtask

    task automatic pause_action();
        int a = $urandom_range(0, 3);
        int f0;
        if (a == 0) begin
            if (m_hit != 0) run = 1'($urandom_range(0, 1));
            f0 = fall_cnt;
            repeat (20) @(negedge CLK);
            check("pause_no_cycle", fall_cnt, f0);
            check("pause_cpu_clk", cpu_clk, 0);
            check("pause_state", state, 2);
            check("pause_bp_hit", bp_hit, m_hit);
        end else if (a == 1) begin
            f0 = fall_cnt;
            step_btn = 1'b1;
            repeat (DEBOUNCE - 1) @(negedge CLK);
            step_btn = 1'b0;
            repeat (20) @(negedge CLK);
            check("glitch_no_cycle", fall_cnt, f0);
            check("glitch_state", state, 2);
        end else if (a == 2 && m_hit == 0) begin
            run = 1'b1;
            @(negedge CLK);
            check("resume_state", state, 1);
            m_state = 1;
        end else begin
            int p0 = rel_edge;
            int d;
            step_btn = 1'b1;
            repeat (DEBOUNCE + 3) @(negedge CLK);
            step_btn = 1'b0;
            wait_rise();
            d = rise_edge - p0;
            check("step_latency_ok", (d >= DEBOUNCE + 4) && (d <= DEBOUNCE + 3 + DIV), 1);
            run     = 1'($urandom_range(0, 1));
            bp_en   = 1'($urandom_range(0, 1));
            bp_addr = 16'($urandom);
            if ($urandom_range(0, 5) == 0) addr_bus = bp_addr;
            else                           addr_bus = 16'($urandom);
            m_hit = 0;
            model_cycle();
            wait_fall();
            if (m_state == 2) repeat (DEBOUNCE) @(negedge CLK);
        end
    endtask

    task automatic random_loop(input longint stop_count);
        int iter = 0;
        while (m_state != 3 && !(m_state == 1 && m_count >= stop_count) && iter < 1500) begin
            iter++;
            if (m_state == 1) run_cycle();
            else              pause_action();
        end
    endtask

    task automatic done_phase();
        int r0 = rise_cnt;
        check("done_state", state, 3);
        check("done_count", cycle_count, RUN_CYCLES);
        repeat (2) begin
            step_btn = 1'b1;
            repeat (8) @(negedge CLK);
            step_btn = 1'b0;
            repeat (12) @(negedge CLK);
        end
        repeat (60) @(negedge CLK);
        check("done_no_rise", rise_cnt, r0);
        check("done_cpu_clk", cpu_clk, 0);
        check("done_cpu_res", cpu_res, 0);
        check("done_state_hold", state, 3);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            start_run();
            random_loop(64'd1 << 40);
            done_phase();
        end
        start_run();
        random_loop(8);
        wait_rise();
        check("pre_reset_cpu_clk", cpu_clk, 1);
        R = 1'b1;
        @(negedge CLK);
        check("midreset_cpu_clk", cpu_clk, 0);
        check("midreset_cpu_res", cpu_res, 1);
        check("midreset_count", cycle_count, 0);
        check("midreset_state", state, 0);
        start_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
